// File: rtl/pipelined_dma_fpu_arbiter.sv
// Fixed-priority three-master memory-bus arbiter: DMA (A) > FPU (C) > CPU (B).
// One transaction per grant, a registered arbitration decision, combinational
// Q-bus muxing and ack routing, and a broadcast read-data path.
// Optional CPU starvation guard: define ARB_CPU_STARVE_GUARD_EN.
module pipelined_dma_fpu_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  // A bus: DMA controller
  input  logic [19:1] a_m_addr,
  output logic [15:0] a_m_data_in,
  input  logic [15:0] a_m_data_out,
  input  logic        a_m_access,
  output logic        a_m_ack,
  input  logic        a_m_wr_en,
  input  logic [1:0]  a_m_bytesel,
  input  logic        ioa,
  // B bus: CPU cache
  input  logic [19:1] b_m_addr,
  output logic [15:0] b_m_data_in,
  input  logic [15:0] b_m_data_out,
  input  logic        b_m_access,
  output logic        b_m_ack,
  input  logic        b_m_wr_en,
  input  logic [1:0]  b_m_bytesel,
  input  logic        iob,
  // C bus: FPU memory port
  input  logic [19:1] c_m_addr,
  output logic [15:0] c_m_data_in,
  input  logic [15:0] c_m_data_out,
  input  logic        c_m_access,
  output logic        c_m_ack,
  input  logic        c_m_wr_en,
  input  logic [1:0]  c_m_bytesel,
  // Q bus: shared slave
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        ioq,
  output logic [1:0]  q_grant
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;
  localparam logic [1:0] GRANT_C    = 2'b11;

  state_t     state;
  logic [1:0] grant;
  logic [1:0] next_grant;
  logic       starved;

`ifdef ARB_CPU_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Count A/C grants that bypass a waiting CPU; saturate at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!b_m_access) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (next_grant == GRANT_B) begin
        starve_cnt <= '0;
      end else if (next_grant != GRANT_NONE && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Priority pick among current requesters; only consumed while IDLE.
  always_comb begin
    // NOTE: default first so every path assigns next_grant and no latch is inferred.
    next_grant = GRANT_NONE;
    if (starved && b_m_access) begin
      next_grant = GRANT_B;
    end else if (a_m_access) begin
      next_grant = GRANT_A;
    end else if (c_m_access) begin
      next_grant = GRANT_C;
    end else if (b_m_access) begin
      next_grant = GRANT_B;
    end
  end

  // Arbitration FSM: grant from IDLE, hold the owner until the slave acks.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state uses non-blocking assignments and the async active-low reset
    // clears it immediately, abandoning any transfer in flight.
    if (!reset) begin
      state <= IDLE;
      grant <= GRANT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (next_grant != GRANT_NONE) begin
            grant <= next_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (q_m_ack) begin
            grant <= GRANT_NONE;
            state <= IDLE;
          end
        end
        default: begin
          grant <= GRANT_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

  assign q_grant    = grant;
  assign q_m_access = (state == BUSY);

  // Forward the owner's request fields; all zero when nobody owns the bus.
  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = '0;
    ioq          = 1'b0;
    case (grant)
      GRANT_A: begin
        q_m_addr     = a_m_addr;
        q_m_data_out = a_m_data_out;
        q_m_wr_en    = a_m_wr_en;
        q_m_bytesel  = a_m_bytesel;
        ioq          = ioa;
      end
      GRANT_B: begin
        q_m_addr     = b_m_addr;
        q_m_data_out = b_m_data_out;
        q_m_wr_en    = b_m_wr_en;
        q_m_bytesel  = b_m_bytesel;
        ioq          = iob;
      end
      GRANT_C: begin
        q_m_addr     = c_m_addr;
        q_m_data_out = c_m_data_out;
        q_m_wr_en    = c_m_wr_en;
        q_m_bytesel  = c_m_bytesel;
        ioq          = 1'b0;
      end
      default: ;
    endcase
  end

  // The slave ack reaches only the owner; grant is 00 in IDLE so stray acks vanish.
  assign a_m_ack = q_m_ack && (grant == GRANT_A);
  assign b_m_ack = q_m_ack && (grant == GRANT_B);
  assign c_m_ack = q_m_ack && (grant == GRANT_C);

  // Read data is broadcast; each master qualifies it with its own ack.
  assign a_m_data_in = q_m_data_in;
  assign b_m_data_in = q_m_data_in;
  assign c_m_data_in = q_m_data_in;

endmodule

// File: tb/tb_pipelined_dma_fpu_arbiter.sv
// Scoreboard bench for pipelined_dma_fpu_arbiter: master tasks push expected
// transactions, a negedge monitor pops them on each ack and checks arbitration.
module tb_pipelined_dma_fpu_arbiter;

  localparam int TIMEOUT = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:1] a_m_addr = '0, b_m_addr = '0, c_m_addr = '0;
  logic [15:0] a_m_data_out = '0, b_m_data_out = '0, c_m_data_out = '0;
  logic        a_m_access = 1'b0, b_m_access = 1'b0, c_m_access = 1'b0;
  logic        a_m_wr_en = 1'b0, b_m_wr_en = 1'b0, c_m_wr_en = 1'b0;
  logic [1:0]  a_m_bytesel = '0, b_m_bytesel = '0, c_m_bytesel = '0;
  logic        ioa = 1'b0, iob = 1'b0;
  logic [15:0] a_m_data_in, b_m_data_in, c_m_data_in;
  logic        a_m_ack, b_m_ack, c_m_ack;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in = '0;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack = 1'b0;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        ioq;
  logic [1:0]  q_grant;

  int checks = 0;
  int errors = 0;

  pipelined_dma_fpu_arbiter dut (
    .clk(clk), .reset(reset),
    .a_m_addr(a_m_addr), .a_m_data_in(a_m_data_in), .a_m_data_out(a_m_data_out),
    .a_m_access(a_m_access), .a_m_ack(a_m_ack), .a_m_wr_en(a_m_wr_en),
    .a_m_bytesel(a_m_bytesel), .ioa(ioa),
    .b_m_addr(b_m_addr), .b_m_data_in(b_m_data_in), .b_m_data_out(b_m_data_out),
    .b_m_access(b_m_access), .b_m_ack(b_m_ack), .b_m_wr_en(b_m_wr_en),
    .b_m_bytesel(b_m_bytesel), .iob(iob),
    .c_m_addr(c_m_addr), .c_m_data_in(c_m_data_in), .c_m_data_out(c_m_data_out),
    .c_m_access(c_m_access), .c_m_ack(c_m_ack), .c_m_wr_en(c_m_wr_en),
    .c_m_bytesel(c_m_bytesel),
    .q_m_addr(q_m_addr), .q_m_data_in(q_m_data_in), .q_m_data_out(q_m_data_out),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .ioq(ioq), .q_grant(q_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- slave memory (environment) ----------------
  logic [15:0] slave_mem [0:16383];
  bit          slave_hold = 1'b0;
  bit          rand_wait = 1'b0;
  int          slave_wait = 0;
  int          wait_cnt = 0;

  initial for (int i = 0; i < 16384; i++) slave_mem[i] = 16'(i);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_m_ack  <= 1'b0;
      wait_cnt <= 0;
    end else begin
      q_m_ack <= 1'b0;
      if (q_m_access && !q_m_ack && !slave_hold) begin
        if (wait_cnt >= slave_wait) begin
          q_m_ack  <= 1'b1;
          wait_cnt <= 0;
          slave_wait <= rand_wait ? int'($urandom_range(0, 2)) : 0;
          if (q_m_wr_en)
            slave_mem[q_m_addr[14:1]] <= {
              q_m_bytesel[1] ? q_m_data_out[15:8] : slave_mem[q_m_addr[14:1]][15:8],
              q_m_bytesel[0] ? q_m_data_out[7:0]  : slave_mem[q_m_addr[14:1]][7:0]};
          else
            q_m_data_in <= slave_mem[q_m_addr[14:1]];
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [18:0] addr;
    logic        wr;
    logic [15:0] data;
    logic [1:0]  bs;
    logic        io;
    logic [15:0] rdata;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  logic [15:0] ref_mem [int];

  // Unwritten words read back as their own address.
  function automatic logic [15:0] ref_read(input logic [18:0] addr);
    if (ref_mem.exists(int'(addr))) return ref_mem[int'(addr)];
    return addr[15:0];
  endfunction

  function automatic void ref_write(input logic [18:0] addr, input logic [15:0] d,
                                    input logic [1:0] bs);
    logic [15:0] old;
    old = ref_read(addr);
    if (bs[1]) old[15:8] = d[15:8];
    if (bs[0]) old[7:0]  = d[7:0];
    ref_mem[int'(addr)] = old;
  endfunction

  function automatic logic master_ack(input int m);
    case (m)
      0: return a_m_ack;
      1: return b_m_ack;
      default: return c_m_ack;
    endcase
  endfunction

  task automatic drive(input int m, input logic acc, input logic [18:0] addr,
                       input logic wr, input logic [15:0] d, input logic [1:0] bs,
                       input logic io);
    case (m)
      0: begin a_m_access = acc; a_m_addr = addr; a_m_wr_en = wr;
               a_m_data_out = d; a_m_bytesel = bs; ioa = io; end
      1: begin b_m_access = acc; b_m_addr = addr; b_m_wr_en = wr;
               b_m_data_out = d; b_m_bytesel = bs; iob = io; end
      default: begin c_m_access = acc; c_m_addr = addr; c_m_wr_en = wr;
               c_m_data_out = d; c_m_bytesel = bs; end
    endcase
  endtask

  task automatic drop_access(input int m);
    case (m)
      0: a_m_access = 1'b0;
      1: b_m_access = 1'b0;
      default: c_m_access = 1'b0;
    endcase
  endtask

  // One master transaction: 0=A (DMA), 1=B (CPU), 2=C (FPU).
  task automatic run_master(input int m, input logic [18:0] addr, input logic wr,
                            input logic [15:0] d, input logic [1:0] bs,
                            input logic io, input bit early_drop, output int cycles);
    exp_t e;
    logic [1:0] code;
    bit done;
    code = (m == 0) ? 2'b01 : (m == 1) ? 2'b10 : 2'b11;
    e.addr = addr; e.wr = wr; e.data = d; e.bs = bs;
    e.io = (m == 2) ? 1'b0 : io;
    e.rdata = ref_read(addr);
    if (wr) ref_write(addr, d, bs);
    case (m)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
    drive(m, 1'b1, addr, wr, d, bs, io);
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < TIMEOUT) begin
      @(posedge clk); #1;
      cycles++;
      if (master_ack(m)) done = 1'b1;
      else if (early_drop && q_grant == code) drop_access(m);
    end
    if (!done) check($sformatf("timeout_master%0d", m), 32'(cycles), 0);
    drop_access(m);
    @(posedge clk); #1;
  endtask

  task automatic rand_master(input int m, input int n);
    int cyc;
    for (int i = 0; i < n; i++) begin
      run_master(m, 19'(((m + 1) << 12) | int'($urandom_range(0, 63))),
                 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), cyc);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic pop_check(input int m, input logic [15:0] din);
    exp_t e;
    string tag;
    tag = (m == 0) ? "A" : (m == 1) ? "B" : "C";
    if (m == 0 && qa.size() == 0 || m == 1 && qb.size() == 0 || m == 2 && qc.size() == 0) begin
      check({"unexpected_ack_", tag}, 1, 0);
      return;
    end
    case (m)
      0: e = qa.pop_front();
      1: e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
    check({"q_addr_", tag}, 32'(q_m_addr), 32'(e.addr));
    check({"q_wr_", tag}, 32'(q_m_wr_en), 32'(e.wr));
    check({"q_data_out_", tag}, 32'(q_m_data_out), 32'(e.data));
    check({"q_bytesel_", tag}, 32'(q_m_bytesel), 32'(e.bs));
    check({"ioq_", tag}, 32'(ioq), 32'(e.io));
    if (!e.wr) check({"rdata_", tag}, 32'(din), 32'(e.rdata));
  endtask

  // Monitor: arbitration/hold/idle rules and ack scoreboard, sampled at negedge.
  initial begin
    logic [1:0] prev_grant, exp_grant;
    logic prev_ack, prev_a, prev_b, prev_c;
    prev_grant = 2'b00; prev_ack = 1'b0;
    prev_a = 1'b0; prev_b = 1'b0; prev_c = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (prev_grant == 2'b00)
          exp_grant = prev_a ? 2'b01 : prev_c ? 2'b11 : prev_b ? 2'b10 : 2'b00;
        else
          exp_grant = prev_ack ? 2'b00 : prev_grant;
        check("arb_grant", 32'(q_grant), 32'(exp_grant));
        if (q_grant == 2'b00)
          check("idle_q_outputs",
                32'({q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, ioq}), 0);
        else
          check("busy_q_access", 32'(q_m_access), 1);
        check("one_ack_max", 32'(int'(a_m_ack) + int'(b_m_ack) + int'(c_m_ack) > 1), 0);
        if (a_m_ack) pop_check(0, a_m_data_in);
        if (b_m_ack) pop_check(1, b_m_data_in);
        if (c_m_ack) pop_check(2, c_m_data_in);
        prev_grant = q_grant;
        prev_ack = q_m_ack;
      end else begin
        check("reset_outputs", 32'({q_grant, q_m_access, a_m_ack, b_m_ack, c_m_ack}), 0);
        prev_grant = 2'b00;
        prev_ack = 1'b0;
      end
      prev_a = a_m_access; prev_b = b_m_access; prev_c = c_m_access;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q_grant", 32'(q_grant), 0);
    check("reset_q_access", 32'(q_m_access), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // CPU read of word 5, one-cycle slave: ack after two edges.
    run_master(1, 19'd5, 1'b0, 16'h0, 2'b11, 1'b0, 1'b0, cyc);
    check("cpu_read_latency", 32'(cyc), 2);
    check("broadcast_a", 32'(a_m_data_in), 32'h0005);
    check("broadcast_c", 32'(c_m_data_in), 32'h0005);

    // FPU write 0xABCD to word 0x14.
    run_master(2, 19'h14, 1'b1, 16'hABCD, 2'b11, 1'b0, 1'b0, cyc);
    check("fpu_write_mem", 32'(slave_mem[20]), 32'hABCD);

    // DMA and FPU together: A first, then C.
    fork
      run_master(0, 19'h19, 1'b0, 16'h1111, 2'b11, 1'b0, 1'b0, cyc);
      begin int c2; run_master(2, 19'h1E, 1'b0, 16'h2222, 2'b11, 1'b0, 1'b0, c2); end
    join

    // FPU and CPU together: C first, then B.
    fork
      run_master(2, 19'h2D, 1'b0, 16'h3333, 2'b11, 1'b0, 1'b0, cyc);
      begin int c2; run_master(1, 19'h32, 1'b0, 16'h4444, 2'b11, 1'b0, 1'b0, c2); end
    join

    // All three together with IO qualifiers set: A, C, B.
    fork
      run_master(0, 19'h37, 1'b0, 16'h5555, 2'b01, 1'b1, 1'b0, cyc);
      begin int c2; run_master(1, 19'h3C, 1'b1, 16'h6666, 2'b10, 1'b1, 1'b0, c2); end
      begin int c3; run_master(2, 19'h41, 1'b0, 16'h7777, 2'b11, 1'b1, 1'b0, c3); end
    join

    // Reset while BUSY: transfer abandoned, no ack afterwards.
    slave_hold = 1'b1;
    drive(1, 1'b1, 19'h50, 1'b0, 16'h0, 2'b11, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_grant", 32'(q_grant), 32'h2);
    reset = 1'b0;
    #1;
    check("mid_reset_grant", 32'(q_grant), 0);
    check("mid_reset_access", 32'(q_m_access), 0);
    drop_access(1);
    slave_hold = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("post_reset_grant", 32'(q_grant), 0);

    // Randomized traffic from all three masters with variable slave latency.
    rand_wait = 1'b1;
    fork
      rand_master(0, 25);
      rand_master(1, 25);
      rand_master(2, 25);
    join
    repeat (4) @(posedge clk);

    check("scoreboard_a_empty", 32'(qa.size()), 0);
    check("scoreboard_b_empty", 32'(qb.size()), 0);
    check("scoreboard_c_empty", 32'(qc.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_dma_fpu_arbiter.md
Name: pipelined_dma_fpu_arbiter

Overview:
- Three-master, one-slave memory-bus arbiter with fixed priority: DMA (A-bus) > FPU (C-bus) > CPU cache (B-bus).
- Sits between the DMA controller, FPU memory port and CPU cache, and the shared memory/IO bus.
- Grants one master per transaction, muxes its request onto the Q bus, and returns the slave ack only to the granted master.
- Arbitration decision is registered, so a new grant is issued in the cycle after the bus is observed idle.

Parameters:
- STARVE_LIMIT, 8: consecutive higher-priority grants allowed while the CPU waits; used only with the optional feature.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- a_m_addr  input  19  DMA word address [19:1]
- a_m_data_in  output  16  read data to DMA
- a_m_data_out  input  16  write data from DMA
- a_m_access  input  1  DMA request
- a_m_ack  output  1  DMA transfer complete
- a_m_wr_en  input  1  DMA write
- a_m_bytesel  input  2  DMA byte enables
- ioa  input  1  DMA IO-space qualifier
- b_m_addr, b_m_data_in, b_m_data_out, b_m_access, b_m_ack, b_m_wr_en, b_m_bytesel, iob: CPU-side equivalents, same directions and widths as A
- c_m_addr, c_m_data_in, c_m_data_out, c_m_access, c_m_ack, c_m_wr_en, c_m_bytesel: FPU-side equivalents; the FPU has no IO qualifier
- q_m_addr  output  19  slave address
- q_m_data_in  input  16  slave read data
- q_m_data_out  output  16  slave write data
- q_m_access  output  1  slave request
- q_m_ack  input  1  slave completion
- q_m_wr_en  output  1  slave write
- q_m_bytesel  output  2  slave byte enables
- ioq  output  1  slave IO qualifier
- q_grant  output  2  current owner: 00 none, 01 A (DMA), 10 B (CPU), 11 C (FPU)

Behaviour:
- States: IDLE, BUSY. The q_grant register is 00 in IDLE and nonzero in BUSY.
- Reset (reset=0): immediately force q_grant=00, state IDLE, q_m_access=0, all x_m_ack=0 and the starvation counter to 0. Reset asserted mid-transaction abandons the transfer; no ack is forwarded.
- IDLE, rising edge:
  - a_m_access=1: grant 01.
  - else c_m_access=1: grant 11.
  - else b_m_access=1: grant 10.
  - Otherwise stay IDLE.
- BUSY, combinational outputs:
  - q_m_access=1.
  - q_m_addr, q_m_data_out, q_m_wr_en and q_m_bytesel come from the granted bus.
  - ioq = ioa for A, iob for B, 0 for C.
- IDLE, combinational outputs: q_m_access=0 and all Q outputs are 0.
- Ack routing: x_m_ack = q_m_ack AND (q_grant selects x), purely combinational. q_grant is still valid during the ack cycle. q_m_ack seen in IDLE is ignored.
- Completion: at the rising edge where state is BUSY and q_m_ack=1, return to IDLE (q_grant=00). The next grant can occur at the following edge, so there is a minimum of one idle cycle between transactions. This stops a master that drops access on the edge after its ack from being re-granted.
- Grant hold: the grant is held until q_m_ack even if the master drops access early. The slave transaction always completes and the ack is still pulsed to that master.
- Read data: a_m_data_in, b_m_data_in and c_m_data_in are all continuously driven with q_m_data_in (broadcast). A master qualifies the data with its own ack. The value persists as long as the slave holds q_m_data_in.
- Latency with a one-cycle slave:
  - Request sampled at edge N.
  - Grant and q_m_access valid after N.
  - Slave ack after N+1; x_m_ack high during N+1..N+2.
  - IDLE after N+2.
- Simultaneous requests are served strictly by priority, one transaction each. A lower-priority master waits while higher-priority requests remain asserted; starvation is possible without the optional feature.

Optional Feature:
- Macro: ARB_CPU_STARVE_GUARD_EN.
- When defined:
  - The counter increments on each A or C grant issued while b_m_access=1.
  - The counter clears on a B grant or when b_m_access=0.
  - When counter ≥ STARVE_LIMIT, the next IDLE arbitration grants B (if requesting) ahead of A and C.
- When undefined: pure fixed priority and no counter logic.

Test Plan:
- CPU read, memory[5]=0x0005, b_m_addr=5 -> b_m_ack pulses with q_grant=10; b_m_data_in=0x0005; a_m_ack and c_m_ack stay 0.
- FPU write, c_m_addr=0x14, c_m_data_out=0xABCD, c_m_wr_en=1 -> q_m_wr_en=1, q_m_data_out=0xABCD; memory[20]=0xABCD after c_m_ack.
- DMA and FPU simultaneous (addr 0x19, 0x1E) -> a_m_ack first with q_grant=01; after DMA drops, c_m_ack with q_grant=11 and c_m_data_in=0x001E.
- FPU and CPU simultaneous (0x2D, 0x32) -> c_m_ack with q_grant=11, then b_m_ack with q_grant=10.
- All three simultaneous (0x37, 0x3C, 0x41) -> acks in order A (01), C (11), B (10), each separated by one idle cycle; ioq mirrors ioa/iob for A/B and is 0 for C.
- Reset asserted while BUSY -> q_grant=00 and q_m_access=0 immediately; no x_m_ack pulse follows.
